// File: rtl/rvj1_defines.sv
// Shared constants and types for the rvj1 memory arbiter.
package rvj1_defines;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_owner_e;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } arb_lock_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [NBYTES-1:0] strobe;
        logic              write;
    } arb_req_t;

endpackage

// File: rtl/rvj1_mem_arbiter_if.sv
// Request/response channels of the two requesters and the shared bus.
interface rvj1_mem_arbiter_if;
    import rvj1_defines::*;

    logic [XLEN-1:0]   instr_req_addr_i;
    logic [XLEN-1:0]   instr_req_data_i;
    logic [NBYTES-1:0] instr_req_strobe_i;
    logic              instr_req_write_i;
    logic              instr_req_valid_i;
    logic              instr_req_ready_o;
    logic [XLEN-1:0]   instr_rsp_data_o;
    logic              instr_rsp_error_o;
    logic              instr_rsp_valid_o;
    logic              instr_rsp_ready_i;

    logic [XLEN-1:0]   data_req_addr_i;
    logic [XLEN-1:0]   data_req_data_i;
    logic [NBYTES-1:0] data_req_strobe_i;
    logic              data_req_write_i;
    logic              data_req_valid_i;
    logic              data_req_ready_o;
    logic [XLEN-1:0]   data_rsp_data_o;
    logic              data_rsp_error_o;
    logic              data_rsp_valid_o;
    logic              data_rsp_ready_i;

    logic [XLEN-1:0]   bus_req_addr_o;
    logic [XLEN-1:0]   bus_req_data_o;
    logic [NBYTES-1:0] bus_req_strobe_o;
    logic              bus_req_write_o;
    logic              bus_req_valid_o;
    logic              bus_req_ready_i;
    logic [XLEN-1:0]   bus_rsp_data_i;
    logic              bus_rsp_error_i;
    logic              bus_rsp_valid_i;
    logic              bus_rsp_ready_o;
    logic              spur_rsp_o;

    // Arbiter view.
    modport slave (
        input  instr_req_addr_i, instr_req_data_i, instr_req_strobe_i, instr_req_write_i,
        input  instr_req_valid_i, instr_rsp_ready_i,
        output instr_req_ready_o, instr_rsp_data_o, instr_rsp_error_o, instr_rsp_valid_o,
        input  data_req_addr_i, data_req_data_i, data_req_strobe_i, data_req_write_i,
        input  data_req_valid_i, data_rsp_ready_i,
        output data_req_ready_o, data_rsp_data_o, data_rsp_error_o, data_rsp_valid_o,
        output bus_req_addr_o, bus_req_data_o, bus_req_strobe_o, bus_req_write_o,
        output bus_req_valid_o, bus_rsp_ready_o, spur_rsp_o,
        input  bus_req_ready_i, bus_rsp_data_i, bus_rsp_error_i, bus_rsp_valid_i
    );

    // Environment view: drives both requesters and the downstream bus.
    modport master (
        output instr_req_addr_i, instr_req_data_i, instr_req_strobe_i, instr_req_write_i,
        output instr_req_valid_i, instr_rsp_ready_i,
        input  instr_req_ready_o, instr_rsp_data_o, instr_rsp_error_o, instr_rsp_valid_o,
        output data_req_addr_i, data_req_data_i, data_req_strobe_i, data_req_write_i,
        output data_req_valid_i, data_rsp_ready_i,
        input  data_req_ready_o, data_rsp_data_o, data_rsp_error_o, data_rsp_valid_o,
        input  bus_req_addr_o, bus_req_data_o, bus_req_strobe_o, bus_req_write_o,
        input  bus_req_valid_o, bus_rsp_ready_o, spur_rsp_o,
        output bus_req_ready_i, bus_rsp_data_i, bus_rsp_error_i, bus_rsp_valid_i
    );

endinterface

// File: rtl/rvj1_arb_owner_fifo.sv
// Records the owner of every accepted bus request until its response returns.
module rvj1_arb_owner_fifo
    import rvj1_defines::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  arb_owner_e owner_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output arb_owner_e head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    arb_owner_e         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= owner_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rvj1_mem_arbiter.sv
// Two-to-one arbiter sharing one memory bus between fetch and LSU ports.
// Define RVJ1_ARB_ROUND_ROBIN_EN for round-robin ties; default is DATA-priority.
module rvj1_mem_arbiter
    import rvj1_defines::*;
#(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rvj1_mem_arbiter_if.slave arb_if
);

    arb_lock_e  lock_q, lock_d;
    arb_owner_e lock_owner_q, lock_owner_d;
    arb_owner_e sel;
    arb_owner_e tie_winner;
    arb_owner_e head;
    arb_req_t   instr_req, data_req, sel_req;
    logic       sel_valid;
    logic       req_go;
    logic       fifo_full, fifo_empty;
    logic       push, pop;

    assign instr_req = '{addr:   arb_if.instr_req_addr_i,
                         data:   arb_if.instr_req_data_i,
                         strobe: arb_if.instr_req_strobe_i,
                         write:  arb_if.instr_req_write_i};
    assign data_req  = '{addr:   arb_if.data_req_addr_i,
                         data:   arb_if.data_req_data_i,
                         strobe: arb_if.data_req_strobe_i,
                         write:  arb_if.data_req_write_i};

`ifdef RVJ1_ARB_ROUND_ROBIN_EN
    arb_owner_e last_grant_q;

    assign tie_winner = (last_grant_q == ARB_DATA) ? ARB_INSTR : ARB_DATA;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= ARB_DATA;
        end else if (push) begin
            last_grant_q <= sel;
        end
    end
`else
    assign tie_winner = ARB_DATA;
`endif

    // A stalled owner keeps the channel until its request transfers.
    always_comb begin
        sel = ARB_DATA;
        if (lock_q == LOCK_HELD) begin
            sel = lock_owner_q;
        end else if (arb_if.instr_req_valid_i && arb_if.data_req_valid_i) begin
            sel = tie_winner;
        end else if (arb_if.instr_req_valid_i) begin
            sel = ARB_INSTR;
        end
    end

    assign sel_valid = (sel == ARB_INSTR) ? arb_if.instr_req_valid_i : arb_if.data_req_valid_i;
    assign sel_req   = (sel == ARB_INSTR) ? instr_req : data_req;
    assign req_go    = !rst_i && !fifo_full;

    assign arb_if.bus_req_addr_o    = sel_req.addr;
    assign arb_if.bus_req_data_o    = sel_req.data;
    assign arb_if.bus_req_strobe_o  = sel_req.strobe;
    assign arb_if.bus_req_write_o   = sel_req.write;
    assign arb_if.bus_req_valid_o   = sel_valid && req_go;
    assign arb_if.instr_req_ready_o = (sel == ARB_INSTR) && arb_if.bus_req_ready_i && req_go;
    assign arb_if.data_req_ready_o  = (sel == ARB_DATA) && arb_if.bus_req_ready_i && req_go;

    assign push = arb_if.bus_req_valid_o && arb_if.bus_req_ready_i;

    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (push) begin
            lock_d = LOCK_IDLE;
        end else if (arb_if.bus_req_valid_o) begin
            lock_d       = LOCK_HELD;
            lock_owner_d = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q       <= LOCK_IDLE;
            lock_owner_q <= ARB_DATA;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    rvj1_arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .owner_i (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign arb_if.instr_rsp_data_o  = arb_if.bus_rsp_data_i;
    assign arb_if.instr_rsp_error_o = arb_if.bus_rsp_error_i;
    assign arb_if.data_rsp_data_o   = arb_if.bus_rsp_data_i;
    assign arb_if.data_rsp_error_o  = arb_if.bus_rsp_error_i;

    // Responses follow the oldest owner; with nothing outstanding they are dropped.
    always_comb begin
        arb_if.instr_rsp_valid_o = 1'b0;
        arb_if.data_rsp_valid_o  = 1'b0;
        arb_if.bus_rsp_ready_o   = 1'b0;
        arb_if.spur_rsp_o        = 1'b0;
        pop                      = 1'b0;
        if (!rst_i) begin
            if (fifo_empty) begin
                arb_if.bus_rsp_ready_o = 1'b1;
                arb_if.spur_rsp_o      = arb_if.bus_rsp_valid_i;
            end else begin
                if (head == ARB_INSTR) begin
                    arb_if.instr_rsp_valid_o = arb_if.bus_rsp_valid_i;
                    arb_if.bus_rsp_ready_o   = arb_if.instr_rsp_ready_i;
                end else begin
                    arb_if.data_rsp_valid_o = arb_if.bus_rsp_valid_i;
                    arb_if.bus_rsp_ready_o  = arb_if.data_rsp_ready_i;
                end
                pop = arb_if.bus_rsp_valid_i && arb_if.bus_rsp_ready_o;
            end
        end
    end

endmodule

// File: tb/tb_rvj1_mem_arbiter.sv
// Self-checking bench for rvj1_mem_arbiter: directed scenarios then random traffic.
module tb_rvj1_mem_arbiter;
    import rvj1_defines::*;

    localparam int unsigned MAX_OUTST = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvj1_mem_arbiter_if bif ();

    rvj1_mem_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arb_if (bif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: owner order of accepted requests, a stalled requester, last winner.
    int          own_q[$];
    int          stalled = -1;
    int          last_g  = 1;
    logic [31:0] mem_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    bit          e2e = 1'b0;

    int g;
    bit e_bv, e_ir, e_dr, e_irv, e_drv, e_brr, e_spur;
    bit i_acc, d_acc, r_acc;
    bit ipend, dpend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) + 32'h0000_1234;
    endfunction

    task automatic idle_inputs();
        bif.instr_req_addr_i = '0; bif.instr_req_data_i = '0; bif.instr_req_strobe_i = '0;
        bif.instr_req_write_i = 1'b0; bif.instr_req_valid_i = 1'b0; bif.instr_rsp_ready_i = 1'b1;
        bif.data_req_addr_i = '0; bif.data_req_data_i = '0; bif.data_req_strobe_i = '0;
        bif.data_req_write_i = 1'b0; bif.data_req_valid_i = 1'b0; bif.data_rsp_ready_i = 1'b1;
        bif.bus_req_ready_i = 1'b1; bif.bus_rsp_data_i = '0; bif.bus_rsp_error_i = 1'b0;
        bif.bus_rsp_valid_i = 1'b0;
    endtask

    task automatic sample();
        bit iv, dv, full, irr, drr, rv;
        int n;
        #1;
        iv = bif.instr_req_valid_i; dv = bif.data_req_valid_i;
        irr = bif.instr_rsp_ready_i; drr = bif.data_rsp_ready_i; rv = bif.bus_rsp_valid_i;
        n = own_q.size();
        full = (n == MAX_OUTST);
        if (stalled >= 0) g = stalled;
        else if (iv && dv) begin
`ifdef RVJ1_ARB_ROUND_ROBIN_EN
            g = (last_g == 1) ? 0 : 1;
`else
            g = 1;
`endif
        end else g = iv ? 0 : 1;
        e_bv = !rst && ((g == 0) ? iv : dv) && !full;
        e_ir = !rst && (g == 0) && bif.bus_req_ready_i && !full;
        e_dr = !rst && (g == 1) && bif.bus_req_ready_i && !full;
        if (rst) begin
            e_irv = 0; e_drv = 0; e_brr = 0; e_spur = 0;
        end else if (n == 0) begin
            e_irv = 0; e_drv = 0; e_brr = 1; e_spur = rv;
        end else begin
            e_irv = (own_q[0] == 0) && rv;
            e_drv = (own_q[0] == 1) && rv;
            e_brr = (own_q[0] == 0) ? irr : drr;
            e_spur = 0;
        end
        chk("bus_req_valid", 32'(bif.bus_req_valid_o), 32'(e_bv));
        if (e_bv) begin
            chk("bus_req_addr", bif.bus_req_addr_o, (g == 0) ? bif.instr_req_addr_i : bif.data_req_addr_i);
            chk("bus_req_write", 32'(bif.bus_req_write_o),
                32'((g == 0) ? bif.instr_req_write_i : bif.data_req_write_i));
        end
        if (iv || rst) chk("instr_req_ready", 32'(bif.instr_req_ready_o), 32'(e_ir));
        if (dv || rst) chk("data_req_ready", 32'(bif.data_req_ready_o), 32'(e_dr));
        chk("instr_rsp_valid", 32'(bif.instr_rsp_valid_o), 32'(e_irv));
        chk("data_rsp_valid", 32'(bif.data_rsp_valid_o), 32'(e_drv));
        chk("bus_rsp_ready", 32'(bif.bus_rsp_ready_o), 32'(e_brr));
        chk("spur_rsp", 32'(bif.spur_rsp_o), 32'(e_spur));
        if (e_irv) chk("instr_rsp_error", 32'(bif.instr_rsp_error_o), 32'(bif.bus_rsp_error_i));
        if (e_drv) chk("data_rsp_error", 32'(bif.data_rsp_error_o), 32'(bif.bus_rsp_error_i));
        if (e2e && e_irv && irr)
            chk("instr_e2e_data", bif.instr_rsp_data_o, (exp_i_q.size() > 0) ? exp_i_q[0] : 32'hxxxx_xxxx);
        if (e2e && e_drv && drr)
            chk("data_e2e_data", bif.data_rsp_data_o, (exp_d_q.size() > 0) ? exp_d_q[0] : 32'hxxxx_xxxx);
        i_acc = iv && e_ir;
        d_acc = dv && e_dr;
        r_acc = !rst && rv && e_brr;
    endtask

    task automatic advance();
        logic [31:0] a;
        @(posedge clk);
        if (rst) begin
            own_q.delete(); mem_q.delete(); exp_i_q.delete(); exp_d_q.delete();
            stalled = -1; last_g = 1;
        end else begin
            if (r_acc) begin
                if (own_q.size() > 0) begin
                    if (own_q[0] == 0 && exp_i_q.size() > 0) void'(exp_i_q.pop_front());
                    if (own_q[0] == 1 && exp_d_q.size() > 0) void'(exp_d_q.pop_front());
                    void'(own_q.pop_front());
                end
                if (mem_q.size() > 0) void'(mem_q.pop_front());
            end
            if (e_bv && bif.bus_req_ready_i) begin
                a = (g == 0) ? bif.instr_req_addr_i : bif.data_req_addr_i;
                own_q.push_back(g); last_g = g; stalled = -1;
                mem_q.push_back(rsp_of(a));
                if (g == 0) exp_i_q.push_back(rsp_of(a)); else exp_d_q.push_back(rsp_of(a));
            end else if (e_bv) begin
                stalled = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_a;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // Fetch read with an immediate response routed to the fetch port.
        bif.instr_req_valid_i = 1'b1; bif.instr_req_addr_i = 32'h8000_0000;
        sample();
        chk("t1_bus_addr", bif.bus_req_addr_o, 32'h8000_0000);
        chk("t1_instr_ready", 32'(bif.instr_req_ready_o), 32'd1);
        advance();
        bif.instr_req_valid_i = 1'b0;
        bif.bus_rsp_valid_i = 1'b1; bif.bus_rsp_data_i = 32'hDEAD_BEEF;
        sample();
        chk("t1_rsp_data", bif.instr_rsp_data_o, 32'hDEAD_BEEF);
        chk("t1_rsp_valid", 32'(bif.instr_rsp_valid_o), 32'd1);
        chk("t1_data_rsp_valid", 32'(bif.data_rsp_valid_o), 32'd0);
        advance();

        // Both requesters always valid: tie resolution.
        reset_pulse();
        bif.instr_req_valid_i = 1'b1; bif.instr_req_addr_i = 32'h0000_1000;
        bif.data_req_valid_i  = 1'b1; bif.data_req_addr_i  = 32'h0000_2000;
        for (int k = 0; k < 6; k++) begin
            bif.bus_rsp_valid_i = (k > 0);
            bif.bus_rsp_data_i  = 32'(k);
            sample();
`ifdef RVJ1_ARB_ROUND_ROBIN_EN
            exp_a = (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
`else
            exp_a = 32'h0000_2000;
`endif
            chk("t2_grant", bif.bus_req_addr_o, exp_a);
            advance();
        end
        bif.data_req_valid_i = 1'b0;
        tick();
        bif.instr_req_valid_i = 1'b0;
        tick();
        bif.bus_rsp_valid_i = 1'b0;

        // Stalled fetch keeps the channel while LSU arrives mid-stall.
        reset_pulse();
        bif.bus_req_ready_i = 1'b0;
        bif.instr_req_valid_i = 1'b1; bif.instr_req_addr_i = 32'h0000_3000;
        bif.data_req_addr_i = 32'h0000_4000;
        for (int s = 0; s < 3; s++) begin
            bif.data_req_valid_i = (s >= 1);
            sample();
            chk("t3_stall_addr", bif.bus_req_addr_o, 32'h0000_3000);
            chk("t3_stall_data_ready", 32'(bif.data_req_ready_o), 32'd0);
            advance();
        end
        bif.bus_req_ready_i = 1'b1;
        sample();
        chk("t3_xfer_addr", bif.bus_req_addr_o, 32'h0000_3000);
        chk("t3_xfer_instr_ready", 32'(bif.instr_req_ready_o), 32'd1);
        chk("t3_xfer_data_ready", 32'(bif.data_req_ready_o), 32'd0);
        advance();
        bif.instr_req_valid_i = 1'b0;
        sample();
        chk("t3_data_addr", bif.bus_req_addr_o, 32'h0000_4000);
        chk("t3_data_ready", 32'(bif.data_req_ready_o), 32'd1);
        advance();
        bif.data_req_valid_i = 1'b0;
        bif.bus_rsp_valid_i = 1'b1;
        tick(); tick();
        bif.bus_rsp_valid_i = 1'b0;

        // Owner FIFO full blocks a third request until a response pops.
        reset_pulse();
        bif.instr_req_valid_i = 1'b1;
        bif.instr_req_addr_i = 32'h0000_5000; tick();
        bif.instr_req_addr_i = 32'h0000_5004; tick();
        bif.instr_req_addr_i = 32'h0000_5008;
        sample();
        chk("t4_full_valid", 32'(bif.bus_req_valid_o), 32'd0);
        chk("t4_full_ready", 32'(bif.instr_req_ready_o), 32'd0);
        advance();
        bif.bus_rsp_valid_i = 1'b1; bif.bus_rsp_data_i = 32'h0000_00AA;
        sample();
        chk("t4_pop_cycle_valid", 32'(bif.bus_req_valid_o), 32'd0);
        advance();
        bif.bus_rsp_valid_i = 1'b0;
        sample();
        chk("t4_after_pop_valid", 32'(bif.bus_req_valid_o), 32'd1);
        chk("t4_after_pop_ready", 32'(bif.instr_req_ready_o), 32'd1);
        chk("t4_after_pop_addr", bif.bus_req_addr_o, 32'h0000_5008);
        advance();
        bif.instr_req_valid_i = 1'b0;
        bif.bus_rsp_valid_i = 1'b1;
        tick(); tick();
        bif.bus_rsp_valid_i = 1'b0;

        // In-order response routing and backpressure from the head owner.
        reset_pulse();
        bif.instr_req_valid_i = 1'b1; bif.instr_req_addr_i = 32'h0000_6000; tick();
        bif.instr_req_valid_i = 1'b0;
        bif.data_req_valid_i = 1'b1; bif.data_req_addr_i = 32'h0000_7000; tick();
        bif.data_req_valid_i = 1'b0;
        bif.data_rsp_ready_i = 1'b0;
        bif.bus_rsp_valid_i = 1'b1; bif.bus_rsp_data_i = 32'h0000_0011;
        sample();
        chk("t5_rsp1_data", bif.instr_rsp_data_o, 32'h0000_0011);
        chk("t5_rsp1_instr_valid", 32'(bif.instr_rsp_valid_o), 32'd1);
        chk("t5_rsp1_data_valid", 32'(bif.data_rsp_valid_o), 32'd0);
        advance();
        bif.bus_rsp_data_i = 32'h0000_0022;
        for (int s = 0; s < 2; s++) begin
            sample();
            chk("t5_hold_bus_rsp_ready", 32'(bif.bus_rsp_ready_o), 32'd0);
            chk("t5_hold_data_valid", 32'(bif.data_rsp_valid_o), 32'd1);
            advance();
        end
        bif.data_rsp_ready_i = 1'b1;
        sample();
        chk("t5_rsp2_data", bif.data_rsp_data_o, 32'h0000_0022);
        chk("t5_rsp2_bus_rsp_ready", 32'(bif.bus_rsp_ready_o), 32'd1);
        advance();
        bif.bus_rsp_valid_i = 1'b0;

        // Reset discards ownership; later responses are spurious.
        reset_pulse();
        bif.instr_req_valid_i = 1'b1;
        bif.instr_req_addr_i = 32'h0000_8000; tick();
        bif.instr_req_addr_i = 32'h0000_8004; tick();
        bif.instr_req_valid_i = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        bif.bus_rsp_valid_i = 1'b1; bif.bus_rsp_data_i = 32'h0000_0033;
        sample();
        chk("t6_spur", 32'(bif.spur_rsp_o), 32'd1);
        chk("t6_bus_rsp_ready", 32'(bif.bus_rsp_ready_o), 32'd1);
        chk("t6_instr_rsp_valid", 32'(bif.instr_rsp_valid_o), 32'd0);
        chk("t6_data_rsp_valid", 32'(bif.data_rsp_valid_o), 32'd0);
        advance();
        bif.bus_rsp_valid_i = 1'b0;
        sample();
        chk("t6_spur_end", 32'(bif.spur_rsp_o), 32'd0);
        advance();

        // Random traffic with a simple in-order memory and end-to-end data checks.
        reset_pulse();
        e2e = 1'b1; ipend = 1'b0; dpend = 1'b0; r_acc = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!ipend && $urandom_range(0, 99) < 55) begin
                ipend = 1'b1;
                bif.instr_req_addr_i   = $urandom() & 32'hFFFF_FFFC;
                bif.instr_req_data_i   = $urandom();
                bif.instr_req_strobe_i = 4'($urandom());
                bif.instr_req_write_i  = 1'($urandom_range(0, 1));
            end
            if (!dpend && $urandom_range(0, 99) < 55) begin
                dpend = 1'b1;
                bif.data_req_addr_i   = $urandom() & 32'hFFFF_FFFC;
                bif.data_req_data_i   = $urandom();
                bif.data_req_strobe_i = 4'($urandom());
                bif.data_req_write_i  = 1'($urandom_range(0, 1));
            end
            bif.instr_req_valid_i = ipend;
            bif.data_req_valid_i  = dpend;
            bif.bus_req_ready_i   = ($urandom_range(0, 99) < 70);
            if (!(bif.bus_rsp_valid_i && !r_acc)) begin
                if (mem_q.size() > 0 && $urandom_range(0, 99) < 60) begin
                    bif.bus_rsp_valid_i = 1'b1;
                    bif.bus_rsp_data_i  = mem_q[0];
                    bif.bus_rsp_error_i = 1'($urandom_range(0, 1));
                end else begin
                    bif.bus_rsp_valid_i = 1'b0;
                end
            end
            bif.instr_rsp_ready_i = ($urandom_range(0, 99) < 70);
            bif.data_rsp_ready_i  = ($urandom_range(0, 99) < 70);
            tick();
            if (i_acc) ipend = 1'b0;
            if (d_acc) dpend = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvj1_mem_arbiter.md
# rvj1_mem_arbiter

Two-to-one memory bus arbiter that lets the rvj1 core's instruction-fetch port and LSU data port share a single memory interface. It sits between the core's instr/data request–response channels and one downstream bus. It chooses which requester drives the request channel and holds that choice stable across bus stalls. It records the owner of every accepted request and routes in-order responses back to the owner.

## Interface
Parameters:
- XLEN, 32, data and address width (package constant)
- NBYTES, 4, strobe width, XLEN/8 (package constant)
- MAX_OUTST, 2, maximum accepted-but-unanswered requests; power of two, at least 1

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- instr_req_{addr,data,strobe,write,valid}_i  in  XLEN/XLEN/NBYTES/1/1  fetch request channel
- instr_req_ready_o  out  1  fetch request accepted
- instr_rsp_{data,error,valid}_o  out  XLEN/1/1  fetch response channel
- instr_rsp_ready_i  in  1  fetch response consumed
- data_req_{addr,data,strobe,write,valid}_i  in  XLEN/XLEN/NBYTES/1/1  LSU request channel
- data_req_ready_o  out  1  LSU request accepted
- data_rsp_{data,error,valid}_o  out  XLEN/1/1  LSU response channel
- data_rsp_ready_i  in  1  LSU response consumed
- bus_req_{addr,data,strobe,write,valid}_o  out  XLEN/XLEN/NBYTES/1/1  shared request channel
- bus_req_ready_i  in  1  bus accepts request
- bus_rsp_{data,error,valid}_i  in  XLEN/1/1  shared response channel; responses return in request order
- bus_rsp_ready_o  out  1  arbiter consumes response
- spur_rsp_o  out  1  one-cycle pulse: response arrived with no outstanding request

## Operation
- Handshakes are valid/ready. A transfer occurs on a cycle where both are high. A valid held high is not dropped or changed until it transfers.
- Arbiter state: LOCK (IDLE, or HELD with an owner of INSTR or DATA), last_grant, and an owner FIFO of depth MAX_OUTST.
- In IDLE the arbiter selects between the active requesters. A single active requester wins. On a tie, the rule in Configuration decides.
- The selected requester's request fields drive bus_req_*_o through a combinational mux. bus_req_valid_o is the selected valid gated by "owner FIFO not full". Only the selected requester's req_ready_o follows bus_req_ready_i; the other requester's req_ready_o is 0.
- If bus_req_valid_o=1 and bus_req_ready_i=0, LOCK moves to HELD(owner). While HELD, selection is forced to that owner regardless of other requests. LOCK returns to IDLE on that owner's transfer.
- On each bus request transfer, the owner ID is pushed into the FIFO.
- When the FIFO is full, bus_req_valid_o=0 and both req_ready_o=0. LOCK is kept. A pop and a push never happen in the same cycle while the FIFO is full, so there is no same-cycle bypass.
- When the FIFO is not empty:
  - bus_rsp_*_i are copied to the head owner's rsp_*_o; the other owner's rsp_valid_o is 0.
  - bus_rsp_ready_o equals the head owner's rsp_ready_i.
  - The head entry is popped on a bus response transfer.
- When the FIFO is empty, bus_rsp_ready_o=1 and both rsp_valid_o=0. Any bus_rsp_valid_i is discarded and spur_rsp_o pulses for one cycle.
- Push and pop may occur in the same cycle when the FIFO is not full; the count is then unchanged.

## Timing
- Request path has zero latency: the bus sees the request in the same cycle it is presented. Response path has zero latency in the same way.
- Throughput is one request per cycle while the FIFO has space and the bus is ready.
- Reset value of registered state: LOCK=IDLE, FIFO empty, last_grant=DATA.
- While rst_i=1, all valid/ready outputs are forced to 0: bus_req_valid_o, both req_ready_o, both rsp_valid_o, bus_rsp_ready_o, and spur_rsp_o. Data outputs may take any value.
- If reset is asserted mid-operation, all outstanding ownership is discarded. Responses that arrive for those requests after reset are treated as spurious.

## Configuration
- RVJ1_ARB_ROUND_ROBIN_EN defined: ties are granted to the requester that is not last_grant. last_grant updates to the owner on every bus request transfer. After reset the first tie goes to INSTR.
- Undefined: fixed priority, and DATA wins every tie. The last_grant register is not built.

## Structure
- Shared package rvj1_defines holds XLEN, NBYTES, and the typedef arb_owner_e {ARB_INSTR, ARB_DATA}.
- Sub-module rvj1_arb_owner_fifo holds the owner FIFO. Parameter DEPTH=MAX_OUTST. Outputs full, empty, and head. Pointers wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits tracks occupancy.

## Test plan
- Instr read at 0x8000_0000 with bus ready: bus_req_addr_o=0x8000_0000 in the same cycle. Response 0xDEADBEEF appears on instr_rsp_data_o with instr_rsp_valid_o=1 and data_rsp_valid_o=0.
- Both requesters valid every cycle, bus always ready, responses immediate:
  - Macro undefined: every grant goes to DATA.
  - Macro defined: grants alternate INSTR, DATA, INSTR.
- Instr request stalled by bus_req_ready_i=0 for 3 cycles, with data_req_valid_i rising in stall cycle 2: grant stays INSTR and data_req_ready_o=0 until the instr transfer. DATA is granted in the next cycle.
- MAX_OUTST=2, two transfers with no response: a third request sees ready=0 and bus_req_valid_o=0. It is accepted in the cycle after the first response pops.
- Issue INSTR then DATA, with responses 0x11 then 0x22:
  - 0x11 goes to INSTR and 0x22 goes to DATA.
  - Holding data_rsp_ready_i=0 keeps bus_rsp_ready_o=0 while DATA is the head.
- Pulse rst_i with 2 requests outstanding, then send a bus response: spur_rsp_o pulses for one cycle, bus_rsp_ready_o=1, and no rsp_valid_o is asserted.
